tmds_period_scheduler: RTL and testbench
========================================

Name: tmds_period_scheduler

Overview:
- Sequences the three per-channel TMDS encoders (blue = ch0, green = ch1, red = ch2) for DVI/HDMI output.
- Generates raster timing (h/v counters, syncs, data enable) and schedules the HDMI video preamble and video guard band ahead of every active line.
- Drives the encoders' video_data_enable/c0/c1 inputs and a guard-band override that a downstream mux applies in place of the encoder output.
- Sits between the pixel source (consumes x/y) and the encoders.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch clocks
- H_SYNC, 96, hsync width clocks
- H_BACK, 48, horizontal back porch clocks; must be >= PREAMBLE_LEN + GUARD_LEN
- V_ACTIVE, 480, active lines
- V_FRONT, 10, vertical front porch lines
- V_SYNC, 2, vsync lines
- V_BACK, 33, vertical back porch lines
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync
- PREAMBLE_LEN, 8, preamble clocks
- GUARD_LEN, 2, guard band clocks
- ENCODER_LATENCY, 3, encoder pipeline depth in pixel clocks

Ports:
- pixel_clock  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- hdmi_mode  in  1  1 = HDMI (preamble + guard band); 0 = DVI (plain control periods)
- x  out  12  horizontal position; valid when video_data_enable=1
- y  out  12  vertical position; valid when video_data_enable=1
- frame_start  out  1  one-clock pulse at x=0, y=0
- video_data_enable  out  1  to all three encoders
- ch0_c0, ch0_c1  out  1 each  hsync, vsync (blue encoder)
- ch1_c0, ch1_c1  out  1 each  CTL0, CTL1 (green encoder)
- ch2_c0, ch2_c1  out  1 each  CTL2, CTL3 (red encoder)
- guard_active  out  1  guard band, aligned with encoder inputs
- guard_active_out  out  1  guard_active delayed ENCODER_LATENCY clocks, aligned with encoder outputs
- guard_tmds_ch0, guard_tmds_ch1, guard_tmds_ch2  out  10 each  guard words for the mux

Behaviour:
- Counters:
  - h_count runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK.
  - v_count advances when h_count wraps; runs 0..V_TOTAL-1 and wraps to 0.
  - Line order: active, front, sync, back. Frame order: same.
- Active region: h_count < H_ACTIVE and v_count < V_ACTIVE.
- hsync is HSYNC_POL when H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC, else its inverse. vsync is analogous on v_count (whole lines).
- All outputs are registered. The outputs for count value n appear one clock after the counter holds n; x, y, syncs, enables and CTL bits are mutually aligned.
- State machine:
  - CONTROL: video_data_enable=0, CTL0..3=0.
  - CONTROL -> PREAMBLE when hdmi_mode=1, the next line index is < V_ACTIVE (wrapping from V_TOTAL-1 to 0 counts), and h_count = H_TOTAL-PREAMBLE_LEN-GUARD_LEN.
  - PREAMBLE: PREAMBLE_LEN clocks; CTL0..3 = 1,0,0,0; video_data_enable=0.
  - PREAMBLE -> GUARD.
  - GUARD: GUARD_LEN clocks; guard_active=1; video_data_enable=0; c0/c1 hold the CONTROL values.
  - GUARD -> VIDEO at h_count=0.
  - VIDEO: video_data_enable=1; x=h_count, y=v_count.
  - VIDEO -> CONTROL at h_count=H_ACTIVE.
  - If hdmi_mode=0, CONTROL -> VIDEO directly at an active h_count=0; no preamble and no guard.
- hdmi_mode is sampled only in CONTROL. A change mid-preamble or mid-guard takes effect on the next line.
- ch0_c0/ch0_c1 carry hsync/vsync in every non-VIDEO state. During VIDEO they are don't-care and are driven 0.
- Guard words (constants):
  - ch0 = 10'b1011001100
  - ch1 = 10'b0100110011
  - ch2 = 10'b1011001100
- guard_active_out is an ENCODER_LATENCY-deep shift register of guard_active, cleared by reset.
- Reset:
  - h_count=0, v_count=0, state CONTROL.
  - All outputs 0 except syncs at their deasserted levels.
  - The guard shift register is flushed.
  - The first clock after reset deassertion is h_count=0, v_count=0; frame_start pulses and the line is VIDEO (no preamble for frame 0, line 0).
  - Reset mid-VIDEO drops video_data_enable on the next clock.
- Width: H_TOTAL and V_TOTAL must be <= 4096 (elaboration check).

Decomposition:
- Package tmds_pkg holds:
  - guard word constants
  - video preamble CTL pattern constant (4'b0001 as {CTL3..CTL0})
  - state enum {CONTROL, PREAMBLE, GUARD, VIDEO}
- Sub-module video_timing_counter: h/v counters, sync and active flags.
- Scheduler FSM, CTL mapping and latency shift register stay in this module.

Test Plan:
- Reset release, default 640x480 parameters, hdmi_mode=1 -> frame_start at the first output clock; exactly 640 video_data_enable clocks per line; 480 active lines; frame period 420000 clocks.
- Line 0 end, hdmi_mode=1 -> h_count 790..797 gives ch1_c0=1 and other CTL 0; 798..799 gives guard_active=1 with words 0x2CC/0x133/0x2CC; guard_active_out follows 3 clocks later.
- Last frame line (v_count 524) -> preamble and guard precede line 0 of the next frame; none before lines 480..523.
- hdmi_mode=0 -> no guard_active and CTL0..3 always 0; hsync low for h_count 656..751; vsync low on lines 490..491.
- Toggle hdmi_mode 1->0 during a preamble -> current preamble and guard complete; next line has none.
- Assert reset at x=300 of line 10 -> next clock video_data_enable=0, syncs deasserted; after release the count restarts at 0,0 and frame_start pulses.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared types and constants for the TMDS period scheduler: scheduler states,
// HDMI video guard-band words and the video preamble CTL pattern.
package tmds_pkg;

  typedef enum logic [1:0] {
    CONTROL  = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } sched_state_t;

  localparam logic [9:0] GUARD_WORD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_WORD_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_WORD_CH2 = 10'b1011001100;

  // {CTL3, CTL2, CTL1, CTL0} during the video data preamble
  localparam logic [3:0] PREAMBLE_CTL = 4'b0001;

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v counters with combinational sync levels and active-region flags
// for the count value currently held.
module video_timing_counter
  import tmds_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        srst,
  output logic [11:0] h_count,
  output logic [11:0] v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        next_line_active
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [11:0] h_count_reg;
  logic [11:0] v_count_reg;
  logic [11:0] v_following;

  always_ff @(posedge clk) begin
    if (srst) begin
      h_count_reg <= '0;
      v_count_reg <= '0;
    end else if (h_count_reg == H_LAST) begin
      h_count_reg <= '0;
      v_count_reg <= v_following;
    end else begin
      h_count_reg <= h_count_reg + 12'd1;
    end
  end

  // Index of the line after the current one, wrapping at the frame end.
  assign v_following = (v_count_reg == V_LAST) ? 12'd0 : v_count_reg + 12'd1;

  assign h_count          = h_count_reg;
  assign v_count          = v_count_reg;
  assign hsync            = (h_count_reg >= HS_START && h_count_reg < HS_END) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync            = (v_count_reg >= VS_START && v_count_reg < VS_END) ? VSYNC_POL : ~VSYNC_POL;
  assign active           = (h_count_reg < H_ACT_END) && (v_count_reg < V_ACT_END);
  assign next_line_active = (v_following < V_ACT_END);

endmodule

// File: rtl/tmds_period_scheduler.sv
// Schedules control, preamble, guard-band and video periods for three TMDS
// encoders and supplies the guard-band override aligned to encoder outputs.
module tmds_period_scheduler
  import tmds_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit HSYNC_POL       = 1'b0,
  parameter bit VSYNC_POL       = 1'b0,
  parameter int PREAMBLE_LEN    = 8,
  parameter int GUARD_LEN       = 2,
  parameter int ENCODER_LATENCY = 3
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        hdmi_mode,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        video_data_enable,
  output logic        ch0_c0,
  output logic        ch0_c1,
  output logic        ch1_c0,
  output logic        ch1_c1,
  output logic        ch2_c0,
  output logic        ch2_c1,
  output logic        guard_active,
  output logic        guard_active_out,
  output logic [9:0]  guard_tmds_ch0,
  output logic [9:0]  guard_tmds_ch1,
  output logic [9:0]  guard_tmds_ch2
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] PREAMBLE_START = 12'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [11:0] GUARD_START    = 12'(H_TOTAL - GUARD_LEN);
  localparam logic [11:0] VIDEO_END      = 12'(H_ACTIVE);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
    $error("tmds_period_scheduler: H_TOTAL and V_TOTAL must not exceed 4096");
  end
  if (H_BACK < PREAMBLE_LEN + GUARD_LEN || GUARD_LEN < 1 || ENCODER_LATENCY < 1) begin : g_period_check
    $error("tmds_period_scheduler: back porch too short for preamble and guard band");
  end

  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        next_line_active;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .HSYNC_POL(HSYNC_POL),
    .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk             (pixel_clock),
    .srst            (reset),
    .h_count         (h_count),
    .v_count         (v_count),
    .hsync           (hsync),
    .vsync           (vsync),
    .active          (active),
    .next_line_active(next_line_active)
  );

  // state_next is the period that applies to the count value held right now.
  sched_state_t state_reg;
  sched_state_t state_next;
  logic         de_next;
  logic         sync_c0_next;
  logic         sync_c1_next;
  logic [3:0]   ctl_next;
  logic         guard_next;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_reg <= CONTROL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CONTROL: begin
        // Entering video without a preamble also covers the first line after
        // reset and lines whose preamble slot passed while in DVI mode.
        if (hdmi_mode && next_line_active && h_count == PREAMBLE_START) begin
          state_next = PREAMBLE;
        end else if (active && h_count == 12'd0) begin
          state_next = VIDEO;
        end
      end
      PREAMBLE: if (h_count == GUARD_START) state_next = GUARD;
      GUARD:    if (h_count == 12'd0) state_next = VIDEO;
      VIDEO:    if (h_count == VIDEO_END) state_next = CONTROL;
      default:  state_next = CONTROL;
    endcase

    de_next      = (state_next == VIDEO);
    sync_c0_next = de_next ? 1'b0 : hsync;
    sync_c1_next = de_next ? 1'b0 : vsync;
    ctl_next     = (state_next == PREAMBLE) ? PREAMBLE_CTL : 4'b0000;
    guard_next   = (state_next == GUARD);
  end

  logic [11:0] x_reg;
  logic [11:0] y_reg;
  logic        frame_start_reg;
  logic        de_reg;
  logic        ch0_c0_reg;
  logic        ch0_c1_reg;
  logic [3:0]  ctl_reg;
  logic        guard_active_reg;
  logic [9:0]  word_ch0_reg;
  logic [9:0]  word_ch1_reg;
  logic [9:0]  word_ch2_reg;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      x_reg            <= '0;
      y_reg            <= '0;
      frame_start_reg  <= 1'b0;
      de_reg           <= 1'b0;
      ch0_c0_reg       <= ~HSYNC_POL;
      ch0_c1_reg       <= ~VSYNC_POL;
      ctl_reg          <= '0;
      guard_active_reg <= 1'b0;
      word_ch0_reg     <= '0;
      word_ch1_reg     <= '0;
      word_ch2_reg     <= '0;
    end else begin
      x_reg            <= h_count;
      y_reg            <= v_count;
      frame_start_reg  <= (h_count == 12'd0) && (v_count == 12'd0);
      de_reg           <= de_next;
      ch0_c0_reg       <= sync_c0_next;
      ch0_c1_reg       <= sync_c1_next;
      ctl_reg          <= ctl_next;
      guard_active_reg <= guard_next;
      word_ch0_reg     <= GUARD_WORD_CH0;
      word_ch1_reg     <= GUARD_WORD_CH1;
      word_ch2_reg     <= GUARD_WORD_CH2;
    end
  end

  // Delay line matching the encoder pipeline so the mux swaps in guard words
  // exactly where the encoders emit the guard-band clocks.
  logic guard_pipe_reg [ENCODER_LATENCY];

  genvar gi;
  for (gi = 0; gi < ENCODER_LATENCY; gi++) begin : g_guard_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge pixel_clock) begin
        if (reset) guard_pipe_reg[gi] <= 1'b0;
        else       guard_pipe_reg[gi] <= guard_active_reg;
      end
    end else begin : g_tail
      always_ff @(posedge pixel_clock) begin
        if (reset) guard_pipe_reg[gi] <= 1'b0;
        else       guard_pipe_reg[gi] <= guard_pipe_reg[gi-1];
      end
    end
  end

  assign x                 = x_reg;
  assign y                 = y_reg;
  assign frame_start       = frame_start_reg;
  assign video_data_enable = de_reg;
  assign ch0_c0            = ch0_c0_reg;
  assign ch0_c1            = ch0_c1_reg;
  assign ch1_c0            = ctl_reg[0];
  assign ch1_c1            = ctl_reg[1];
  assign ch2_c0            = ctl_reg[2];
  assign ch2_c1            = ctl_reg[3];
  assign guard_active      = guard_active_reg;
  assign guard_active_out  = guard_pipe_reg[ENCODER_LATENCY-1];
  assign guard_tmds_ch0    = word_ch0_reg;
  assign guard_tmds_ch1    = word_ch1_reg;
  assign guard_tmds_ch2    = word_ch2_reg;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Scoreboard bench for tmds_period_scheduler on a reduced raster: a positional
// reference model queues per-clock expectations, a monitor pops and compares.
module tb_tmds_period_scheduler;

  localparam int HA = 16, HF = 4, HS = 6, HB = 12;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PRE_LEN = 8, GRD_LEN = 2, LAT = 3;
  localparam int PRE_START = HT - PRE_LEN - GRD_LEN;
  localparam int GRD_START = HT - GRD_LEN;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam int N_CYCLES = 9000;

  logic        clk = 1'b0;
  logic        reset;
  logic        hdmi_mode;
  logic [11:0] x, y;
  logic        frame_start, video_data_enable;
  logic        ch0_c0, ch0_c1, ch1_c0, ch1_c1, ch2_c0, ch2_c1;
  logic        guard_active, guard_active_out;
  logic [9:0]  guard_tmds_ch0, guard_tmds_ch1, guard_tmds_ch2;

  always #5 clk = ~clk;

  tmds_period_scheduler #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
    .PREAMBLE_LEN(PRE_LEN), .GUARD_LEN(GRD_LEN), .ENCODER_LATENCY(LAT)
  ) dut (
    .pixel_clock      (clk),
    .reset            (reset),
    .hdmi_mode        (hdmi_mode),
    .x                (x),
    .y                (y),
    .frame_start      (frame_start),
    .video_data_enable(video_data_enable),
    .ch0_c0           (ch0_c0),
    .ch0_c1           (ch0_c1),
    .ch1_c0           (ch1_c0),
    .ch1_c1           (ch1_c1),
    .ch2_c0           (ch2_c0),
    .ch2_c1           (ch2_c1),
    .guard_active     (guard_active),
    .guard_active_out (guard_active_out),
    .guard_tmds_ch0   (guard_tmds_ch0),
    .guard_tmds_ch1   (guard_tmds_ch1),
    .guard_tmds_ch2   (guard_tmds_ch2)
  );

  typedef struct {
    int          cyc;
    bit          rst;
    int          h;
    int          v;
    logic        de, fs, c0, c1, ga, gao;
    logic [3:0]  ctl;
    logic [11:0] xv, yv;
    logic [29:0] words;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  bit   stim_done    = 1'b0;

  // Reference model state: raster position, per-line preamble decision and
  // the guard history used for the encoder-aligned copy.
  int m_h = 0, m_v = 0;
  bit m_sched = 1'b0;
  bit m_hist[$];

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int cyc, input logic rst_in, input logic mode_in);
    exp_t e;
    int   nv;
    bit   act, pre, grd, hs, vs;
    e.cyc = cyc;
    e.rst = rst_in;
    e.h   = m_h;
    e.v   = m_v;
    if (rst_in) begin
      e.de = 0; e.fs = 0; e.c0 = !HPOL; e.c1 = !VPOL;
      e.ga = 0; e.gao = 0; e.ctl = 4'd0; e.xv = '0; e.yv = '0; e.words = '0;
      m_h = 0; m_v = 0; m_sched = 1'b0;
      m_hist.delete();
      for (int i = 0; i < LAT; i++) m_hist.push_back(1'b0);
    end else begin
      nv = (m_v == VT - 1) ? 0 : m_v + 1;
      if (m_h == PRE_START) m_sched = mode_in && (nv < VA);
      act = (m_h < HA) && (m_v < VA);
      pre = m_sched && (m_h >= PRE_START) && (m_h < GRD_START);
      grd = m_sched && (m_h >= GRD_START);
      hs  = (m_h >= HA + HF && m_h < HA + HF + HS) ? HPOL : !HPOL;
      vs  = (m_v >= VA + VF && m_v < VA + VF + VS) ? VPOL : !VPOL;
      e.de    = act;
      e.fs    = (m_h == 0) && (m_v == 0);
      e.c0    = act ? 1'b0 : hs;
      e.c1    = act ? 1'b0 : vs;
      e.ctl   = {3'b000, pre};
      e.ga    = grd;
      e.gao   = m_hist.pop_front();
      m_hist.push_back(grd);
      e.xv    = 12'(m_h);
      e.yv    = 12'(m_v);
      e.words = {10'b1011001100, 10'b0100110011, 10'b1011001100};
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = nv;
      end else begin
        m_h = m_h + 1;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every clock presents one output set; compare it with the oldest expectation.
  initial begin : monitor
    exp_t e;
    int   de_in_line = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (!stim_done) begin
          n_compared++;
          n_mismatched++;
          $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
        end
      end else begin
        e = exp_q.pop_front();
        check("video_data_enable", e.cyc, 32'(video_data_enable), 32'(e.de));
        check("frame_start",       e.cyc, 32'(frame_start),       32'(e.fs));
        check("hsync_c0",          e.cyc, 32'(ch0_c0),            32'(e.c0));
        check("vsync_c1",          e.cyc, 32'(ch0_c1),            32'(e.c1));
        check("ctl3_0",            e.cyc, 32'({ch2_c1, ch2_c0, ch1_c1, ch1_c0}), 32'(e.ctl));
        check("guard_active",      e.cyc, 32'(guard_active),      32'(e.ga));
        check("guard_active_out",  e.cyc, 32'(guard_active_out),  32'(e.gao));
        check("guard_words",       e.cyc, 32'({guard_tmds_ch2, guard_tmds_ch1, guard_tmds_ch0}), 32'(e.words));
        if (e.de) begin
          check("x", e.cyc, 32'(x), 32'(e.xv));
          check("y", e.cyc, 32'(y), 32'(e.yv));
        end
        if (e.rst) de_in_line = 0;
        else if (video_data_enable) de_in_line++;
        if (!e.rst && e.h == HT - 1) begin
          $display("line v=%0d done at cycle %0d: %0d enable clocks", e.v, e.cyc, de_in_line);
          de_in_line = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int toggle_cyc = -1;
    bit dir_reset_done = 1'b0;
    reset     = 1'b1;
    hdmi_mode = 1'b1;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      if (cyc < 3) begin
        reset = 1'b1;
        hdmi_mode = 1'b1;
      end else if (cyc < 1200) begin
        reset = 1'b0;
        hdmi_mode = 1'b1;
      end else if (cyc < 1800) begin
        reset = 1'b0;
        hdmi_mode = 1'b0;
      end else if (cyc < 2600) begin
        // Drop HDMI mode partway through a scheduled preamble, restore a line later.
        reset = 1'b0;
        if (toggle_cyc < 0 && cyc > 1900 && m_sched && m_h == PRE_START + 3) toggle_cyc = cyc;
        hdmi_mode = (toggle_cyc >= 0 && cyc < toggle_cyc + HT + 10) ? 1'b0 : 1'b1;
      end else if (!dir_reset_done) begin
        hdmi_mode = 1'b1;
        reset = (m_v == 2 && m_h == 8) ? 1'b1 : 1'b0;
        if (reset) dir_reset_done = 1'b1;
      end else begin
        if ($urandom_range(59, 0) == 0) hdmi_mode = !hdmi_mode;
        reset = ($urandom_range(3999, 0) == 0) ? 1'b1 : 1'b0;
      end
      model_step(cyc, reset, hdmi_mode);
      @(posedge clk);
      @(negedge clk);
      if (n_mismatched >= 50) begin
        $display("FAIL early_stop: got %0d mismatches, expected 0", n_mismatched);
        break;
      end
    end
    stim_done = 1'b1;
    @(posedge clk);
    #2;
    check("scoreboard_drained", -1, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
